ula_seq: RTL

Parametrised, registered successor to the 32-bit combinational ULA. It adds valid/ready handshakes on input and output and a full NZCV flag set. It also adds an iterative shift-add multiplier, giving an eight-operation ALU. It sits between the operand-fetch stage and writeback, and it stalls upstream while a multiply is in progress.

---
 rtl/ula_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ula_seq.sv
// Registered eight-operation ALU with valid/ready handshakes and NZCV flags.
// Define ULA_MUL_EN to build the iterative signed multiplier for func=111.
module ula_seq #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       func,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R,
   output logic             pinV,
   output logic             pinC,
   output logic             pinZ,
   output logic             pinN
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             add_v;
   logic             sub_v;
   logic [WIDTH-1:0] res;
   logic             res_c;
   logic             res_v;
   logic             acc_go;

   assign sum   = {1'b0, A} + {1'b0, B};
   assign diff  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
   assign add_v = (A[WIDTH-1] == B[WIDTH-1]) &&
                  (sum[WIDTH-1] != A[WIDTH-1]);
   assign sub_v = (A[WIDTH-1] != B[WIDTH-1]) &&
                  (diff[WIDTH-1] != A[WIDTH-1]);
   assign acc_go = in_valid && in_ready;

   always_comb begin
      res   = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      unique case (func)
         3'b000: res = A & B;
         3'b001: res = A | B;
         3'b010: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = add_v;
         end
         3'b011: begin
            res   = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
            res_v = sub_v;
         end
         3'b100: res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_v};
         3'b101: res = A ^ B;
         3'b110: res = A << B[SHW-1:0];
         3'b111: res = '0;
      endcase
   end

`ifdef ULA_MUL_EN

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state;
   logic [SHW-1:0]     cnt;
   logic               fin;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] step;
   logic [2*WIDTH-1:0] prod_nx;
   logic [WIDTH-1:0]   mplier;
   logic               last;
   logic               mul_v;

   // the multiplier MSB carries negative weight, so its step subtracts
   assign last    = (cnt == SHW'(WIDTH-1));
   assign step    = mplier[0] ? mcand : '0;
   assign prod_nx = last ? prod - step : prod + step;
   assign mul_v   = !((&prod_nx[2*WIDTH-1:WIDTH-1]) ||
                      !(|prod_nx[2*WIDTH-1:WIDTH-1]));

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         fin       <= 1'b0;
         mcand     <= '0;
         prod      <= '0;
         mplier    <= '0;
         out_valid <= 1'b0;
         R         <= '0;
         pinV      <= 1'b0;
         pinC      <= 1'b0;
         pinZ      <= 1'b0;
         pinN      <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (acc_go && func == 3'b111) begin
                  state  <= BUSY;
                  cnt    <= '0;
                  fin    <= 1'b0;
                  prod   <= '0;
                  mplier <= B;
                  mcand  <= {{WIDTH{A[WIDTH-1]}}, A};
               end else if (acc_go) begin
                  R         <= res;
                  pinC      <= res_c;
                  pinV      <= res_v;
                  pinZ      <= ~|res;
                  pinN      <= res[WIDTH-1];
                  out_valid <= 1'b1;
               end
            end
            BUSY: begin
               if (fin) begin
                  out_valid <= 1'b1;
                  state     <= IDLE;
                  fin       <= 1'b0;
               end else begin
                  prod   <= prod_nx;
                  mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                  mplier <= {1'b0, mplier[WIDTH-1:1]};
                  cnt    <= cnt + SHW'(1);
                  if (last) begin
                     R    <= prod_nx[WIDTH-1:0];
                     pinZ <= ~|prod_nx[WIDTH-1:0];
                     pinN <= prod_nx[WIDTH-1];
                     pinC <= 1'b0;
                     pinV <= mul_v;
                     fin  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

`else

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         R         <= '0;
         pinV      <= 1'b0;
         pinC      <= 1'b0;
         pinZ      <= 1'b0;
         pinN      <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (acc_go) begin
            R         <= res;
            pinC      <= res_c;
            pinV      <= res_v;
            pinZ      <= ~|res;
            pinN      <= res[WIDTH-1];
            out_valid <= 1'b1;
         end
      end
   end

`endif

endmodule
